// File: rtl/alu_rf_pkg.sv
// Shared opcodes, opcode field width and flag bundle for alu_regfile_pipelined.
package alu_rf_pkg;
   localparam int OPC_W = 3;

   localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
   localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
   localparam logic [OPC_W-1:0] OP_AND = 3'd2;
   localparam logic [OPC_W-1:0] OP_OR  = 3'd3;
   localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
   localparam logic [OPC_W-1:0] OP_SHL = 3'd5;
   localparam logic [OPC_W-1:0] OP_SHR = 3'd6;
   localparam logic [OPC_W-1:0] OP_MOV = 3'd7;

   typedef struct packed {
      logic overflow;
      logic c_out;
   } alu_flags_t;
endpackage

// File: rtl/alu_regfile_pipelined_alu_core.sv
// Combinational eight-operation ALU evaluated in the second pipeline stage.
module alu_core
   import alu_rf_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [OPC_W-1:0] i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_overflow,
   output logic             o_c_out
);
   logic [WIDTH:0] w_sum;

   always_comb begin
      w_sum      = '0;
      o_result   = '0;
      o_overflow = 1'b0;
      o_c_out    = 1'b0;
      case (i_op)
         OP_ADD: begin
            w_sum      = {1'b0, i_a} + {1'b0, i_b};
            o_result   = w_sum[WIDTH-1:0];
            o_c_out    = w_sum[WIDTH];
            o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_SUB: begin
            // a + ~b + 1, so carry-out high means no borrow
            w_sum      = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
            o_result   = w_sum[WIDTH-1:0];
            o_c_out    = w_sum[WIDTH];
            o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_XOR: o_result = i_a ^ i_b;
         OP_SHL: begin
            o_result = {i_a[WIDTH-2:0], 1'b0};
            o_c_out  = i_a[WIDTH-1];
         end
         OP_SHR: begin
            o_result = {1'b0, i_a[WIDTH-1:1]};
            o_c_out  = i_a[0];
         end
         default: o_result = i_a;
      endcase
   end
endmodule

// File: rtl/alu_regfile_pipelined.sv
// Two-stage ALU + register file with valid/ready issue, host preload and RAW handling.
// Define ALU_FWD_EN to bypass the S2 result into incoming operands instead of stalling.
module alu_regfile_pipelined
   import alu_rf_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int IW     = OPC_W + 3*ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [IW-1:0]     i_instruction,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   input  logic              i_host_wr_en,
   input  logic [ADDR_W-1:0] i_host_wr_addr,
   input  logic [WIDTH-1:0]  i_host_wr_data,
   output logic [WIDTH-1:0]  o_out,
   output logic              o_out_valid,
   output logic              o_overflow,
   output logic              o_c_out
);
   logic [WIDTH-1:0]  r_rf [DEPTH];
   logic [1:0]        r_vld_pipe;  // [0]: S1 occupied, [1]: retire pulse
   logic [OPC_W-1:0]  r_s1_op;
   logic [ADDR_W-1:0] r_s1_rd;
   logic [WIDTH-1:0]  r_s1_a, r_s1_b;
   logic [WIDTH-1:0]  r_out;
   alu_flags_t        r_flags;

   logic [OPC_W-1:0]  w_op;
   logic [ADDR_W-1:0] w_rd, w_ra, w_rb;
   logic              w_haz_a, w_haz_b, w_accept;
   logic [WIDTH-1:0]  w_a, w_b, w_res;
   logic              w_ovf, w_cout;

   assign w_op = i_instruction[IW-1 -: OPC_W];
   assign w_rd = i_instruction[3*ADDR_W-1 -: ADDR_W];
   assign w_ra = i_instruction[2*ADDR_W-1 -: ADDR_W];
   assign w_rb = i_instruction[ADDR_W-1:0];

   assign w_haz_a = r_vld_pipe[0] && (r_s1_rd == w_ra);
   assign w_haz_b = r_vld_pipe[0] && (r_s1_rd == w_rb);

`ifdef ALU_FWD_EN
   assign o_instr_ready = 1'b1;
   assign w_a = w_haz_a ? w_res : r_rf[w_ra];
   assign w_b = w_haz_b ? w_res : r_rf[w_rb];
`else
   // One stall cycle lets S2 write back before the dependent read.
   assign o_instr_ready = ~(w_haz_a | w_haz_b);
   assign w_a = r_rf[w_ra];
   assign w_b = r_rf[w_rb];
`endif

   assign w_accept = i_instr_valid & o_instr_ready;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .i_op       (r_s1_op),
      .i_a        (r_s1_a),
      .i_b        (r_s1_b),
      .o_result   (w_res),
      .o_overflow (w_ovf),
      .o_c_out    (w_cout)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
         r_vld_pipe <= '0;
         r_s1_op    <= '0;
         r_s1_rd    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_out      <= '0;
         r_flags    <= '0;
      end else begin
         if (i_host_wr_en && !(r_vld_pipe[0] && (r_s1_rd == i_host_wr_addr)))
            r_rf[i_host_wr_addr] <= i_host_wr_data;
         if (r_vld_pipe[0]) begin
            r_rf[r_s1_rd] <= w_res;
            r_out         <= w_res;
            r_flags       <= '{overflow: w_ovf, c_out: w_cout};
         end
         r_vld_pipe <= {r_vld_pipe[0], w_accept};
         if (w_accept) begin
            r_s1_op <= w_op;
            r_s1_rd <= w_rd;
            r_s1_a  <= w_a;
            r_s1_b  <= w_b;
         end
      end
   end

   assign o_out       = r_out;
   assign o_out_valid = r_vld_pipe[1];
   assign o_overflow  = r_flags.overflow;
   assign o_c_out     = r_flags.c_out;
endmodule

// File: tb/tb_alu_regfile_pipelined.sv
// Bench for alu_regfile_pipelined: architectural reference model, directed literals, random traffic.
module tb_alu_regfile_pipelined;
`ifdef ALU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] instruction = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic        host_wr_en = 1'b0;
   logic [3:0]  host_wr_addr = '0;
   logic [15:0] host_wr_data = '0;
   logic [15:0] o_out;
   logic        o_out_valid, o_overflow, o_c_out;

   int vectors = 0;
   int miscompares = 0;

   alu_regfile_pipelined #(.WIDTH(16), .DEPTH(16)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_instruction  (instruction),
      .i_instr_valid  (instr_valid),
      .o_instr_ready  (instr_ready),
      .i_host_wr_en   (host_wr_en),
      .i_host_wr_addr (host_wr_addr),
      .i_host_wr_data (host_wr_data),
      .o_out          (o_out),
      .o_out_valid    (o_out_valid),
      .o_overflow     (o_overflow),
      .o_c_out        (o_c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU in plain integer arithmetic: returns {overflow, c_out, result}.
   function automatic logic [17:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int ua, ub, sa, sb, r;
      logic ov, c;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      r = 0; ov = 1'b0; c = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; c = (r > 65535); ov = (sa + sb > 32767) || (sa + sb < -32768); end
         3'd1: begin r = ua - ub; c = (ua >= ub); ov = (sa - sb > 32767) || (sa - sb < -32768); end
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: begin r = ua * 2; c = (ua >= 32768); end
         3'd6: begin r = ua / 2; c = (ua % 2) == 1; end
         default: r = ua;
      endcase
      return {ov, c, r[15:0]};
   endfunction

   // Architectural state plus the one result not yet written back.
   logic [15:0] mrf [16];
   logic        pend_v = 1'b0;
   logic [3:0]  pend_rd;
   logic [15:0] pend_res;
   logic        pend_ovf, pend_c;
   logic        exp_vld = 1'b0, exp_ovf = 1'b0, exp_c = 1'b0;
   logic [15:0] exp_out = '0;
   logic        m_acc;
   logic [15:0] m_a, m_b;
   logic [17:0] m_r;

   function automatic logic model_ready(input logic [14:0] ins);
      return FWD || !(pend_v && (pend_rd == ins[7:4] || pend_rd == ins[3:0]));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mrf[i] = '0;
         pend_v = 1'b0; exp_vld = 1'b0; exp_out = '0; exp_ovf = 1'b0; exp_c = 1'b0;
      end else begin
         m_acc = instr_valid && model_ready(instruction);
         m_r = '0;
         if (m_acc) begin
            m_a = (pend_v && pend_rd == instruction[7:4]) ? pend_res : mrf[instruction[7:4]];
            m_b = (pend_v && pend_rd == instruction[3:0]) ? pend_res : mrf[instruction[3:0]];
            m_r = alu_ref(instruction[14:12], m_a, m_b);
         end
         if (host_wr_en && !(pend_v && pend_rd == host_wr_addr)) mrf[host_wr_addr] = host_wr_data;
         exp_vld = pend_v;
         if (pend_v) begin
            mrf[pend_rd] = pend_res;
            exp_out = pend_res; exp_ovf = pend_ovf; exp_c = pend_c;
         end
         pend_v = m_acc;
         if (m_acc) begin
            pend_rd = instruction[11:8]; pend_res = m_r[15:0]; pend_ovf = m_r[17]; pend_c = m_r[16];
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", 32'(o_out_valid), 32'(exp_vld));
         if (exp_vld) begin
            chk("out", 32'(o_out), 32'(exp_out));
            chk("overflow", 32'(o_overflow), 32'(exp_ovf));
            chk("c_out", 32'(o_c_out), 32'(exp_c));
         end
         if (instr_valid) chk("instr_ready", 32'(instr_ready), 32'(model_ready(instruction)));
      end
   end

   // All tasks begin and end 1 time unit after a rising edge.
   task automatic host(input logic [3:0] addr, input logic [15:0] data);
      host_wr_en = 1'b1; host_wr_addr = addr; host_wr_data = data;
      @(posedge clk); #1;
      host_wr_en = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra,
                        input logic [3:0] rb, output int stalls);
      logic acc;
      stalls = 0;
      instr_valid = 1'b1; instruction = {op, rd, ra, rb};
      forever begin
         @(negedge clk); acc = instr_ready;
         @(posedge clk); #1;
         if (acc) break;
         stalls++;
         if (stalls > 20) begin
            chk("issue_timeout", 32'(stalls), 32'd0);
            break;
         end
      end
      instr_valid = 1'b0;
   endtask

   task automatic run1(input string name, input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [15:0] eo, input logic eov, input logic ec);
      int n;
      issue(op, rd, ra, rb, n);
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, "_valid"}, 32'(o_out_valid), 32'd1);
      chk({name, "_out"}, 32'(o_out), 32'(eo));
      chk({name, "_ovf"}, 32'(o_overflow), 32'(eov));
      chk({name, "_cout"}, 32'(o_c_out), 32'(ec));
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      #12;
      chk("rst_out", 32'(o_out), 32'd0);
      chk("rst_valid", 32'(o_out_valid), 32'd0);
      chk("rst_flags", 32'({o_overflow, o_c_out}), 32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      @(posedge clk); #1; rst = 1'b0;

      host(4'd1, 16'h7FFF);
      host(4'd2, 16'h0001);
      run1("add_ovf", 3'd0, 4'd3, 4'd1, 4'd2, 16'h8000, 1'b1, 1'b0);
      run1("rd_r3",   3'd7, 4'd15, 4'd3, 4'd0, 16'h8000, 1'b0, 1'b0);
      run1("sub_eq",  3'd1, 4'd4, 4'd2, 4'd2, 16'h0000, 1'b0, 1'b1);
      host(4'd5, 16'hFFFF);
      run1("add_cy",  3'd0, 4'd6, 4'd5, 4'd2, 16'h0000, 1'b0, 1'b1);

      issue(3'd0, 4'd7, 4'd1, 4'd2, n);
      issue(3'd0, 4'd8, 4'd7, 4'd2, n);
      chk("raw_stalls", 32'(n), FWD ? 32'd0 : 32'd1);
      @(negedge clk);
      chk("raw_gap", 32'(o_out_valid), 32'(FWD));
      @(posedge clk); #1;
      @(negedge clk);
      chk("raw_valid", 32'(o_out_valid), 32'd1);
      chk("raw_out", 32'(o_out), 32'h8001);
      @(posedge clk); #1;

      run1("shl", 3'd5, 4'd9,  4'd1, 4'd0, 16'hFFFE, 1'b0, 1'b0);
      run1("shr", 3'd6, 4'd10, 4'd2, 4'd0, 16'h0000, 1'b0, 1'b1);
      run1("mov", 3'd7, 4'd11, 4'd1, 4'd0, 16'h7FFF, 1'b0, 1'b0);

      host(4'd14, 16'h00AA);
      issue(3'd7, 4'd12, 4'd14, 4'd0, n);
      host(4'd12, 16'h1234);
      run1("host_lose", 3'd7, 4'd15, 4'd12, 4'd0, 16'h00AA, 1'b0, 1'b0);
      host(4'd13, 16'h5555);
      run1("host_only", 3'd7, 4'd15, 4'd13, 4'd0, 16'h5555, 1'b0, 1'b0);

      issue(3'd0, 4'd9, 4'd1, 4'd2, n);
      issue(3'd0, 4'd10, 4'd1, 4'd1, n);
      rst = 1'b1; #1;
      chk("mid_rst_out", 32'(o_out), 32'd0);
      chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
      chk("mid_rst_flags", 32'({o_overflow, o_c_out}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 32'(o_out_valid), 32'd0);
      @(posedge clk); #1;
      run1("clr_r10", 3'd7, 4'd15, 4'd10, 4'd0, 16'h0000, 1'b0, 1'b0);
      run1("clr_r1",  3'd7, 4'd15, 4'd1, 4'd0, 16'h0000, 1'b0, 1'b0);
      run1("clr_r13", 3'd7, 4'd15, 4'd13, 4'd0, 16'h0000, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) host(4'(i), 16'($urandom));
      for (int c = 0; c < 500; c++) begin
         logic [3:0] rd, ra, rb;
         rd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         rb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         instr_valid  = ($urandom_range(0, 9) < 7);
         instruction  = {3'($urandom), rd, ra, rb};
         host_wr_en   = ($urandom_range(0, 4) == 0);
         host_wr_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         host_wr_data = 16'($urandom);
         @(posedge clk); #1;
      end
      instr_valid = 1'b0; host_wr_en = 1'b0;
      for (int i = 0; i < 16; i++) run1("final_rd", 3'd7, 4'd15, 4'(i), 4'd0, mrf[i], 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_regfile_pipelined.md
# alu_regfile_pipelined

Parametrised, two-stage pipelined successor to the 16-bit ALU-with-register-file. Each accepted instruction reads two registers, executes one of eight ALU operations and writes the result back to a destination register. It adds a valid/ready instruction handshake, a host preload port and RAW-hazard handling. It sits between the instruction source and the datapath consumers, driving a registered result with flags.

## Interface
- WIDTH, 16: datapath and register width (≥4).
- DEPTH, 16: number of registers (power of two, ≥2); ADDR_W = $clog2(DEPTH).
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  3+3*ADDR_W  {opcode[2:0], rd, ra, rb}, MSB first.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept; transfer on valid&ready at a rising edge.
- host_wr_en  in  1  preload write enable.
- host_wr_addr  in  ADDR_W  preload address.
- host_wr_data  in  WIDTH  preload data.
- out  out  WIDTH  registered ALU result.
- out_valid  out  1  one-cycle pulse per retired instruction.
- overflow  out  1  signed overflow of the retired instruction.
- c_out  out  1  carry/shift-out of the retired instruction.

## Operation
- Opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 SHL a by 1; 110 SHR a by 1 (logical); 111 MOV a.
- ADD: c_out = bit WIDTH of the (WIDTH+1)-bit sum; overflow = operands same sign, result sign differs.
- SUB: computed as a+~b+1; c_out = carry (1 means no borrow); overflow = operand signs differ, result sign ≠ a sign.
- SHL: c_out = a[WIDTH-1]. SHR: c_out = a[0]. All other ops: c_out = 0. overflow = 0 for every op except ADD/SUB.
- Stage 1 (S1): on acceptance, opcode, rd and operands a=R[ra], b=R[rb] are registered; s1_valid set.
- Stage 2 (S2): ALU evaluates the S1 registers. At the next edge, out, overflow and c_out are registered, out_valid is set, and R[rd] is written.
- Host port: R[host_wr_addr] <= host_wr_data at the edge. If S2 writes the same address at the same edge, the pipeline write wins and the host write is dropped.
- A register read at the same edge as a host write returns the old value. Host writes are never forwarded.
- No output back-pressure: every accepted instruction retires exactly once.

## Timing
- Reset (async): every register in R = 0; s1_valid = 0; out = 0; out_valid = 0; overflow = 0; c_out = 0. instr_ready = 1 once reset is deasserted.
- An instruction accepted at edge E0 retires at E1: out_valid is high for the cycle following E1, and R[rd] is updated at E1.
- Throughput: one instruction per cycle when there is no hazard.
- RAW hazard: S1 holds a valid instruction whose rd equals the incoming ra or rb.
- Reset asserted mid-operation: all in-flight instructions are discarded and no writeback occurs.

## Configuration
- ALU_FWD_EN defined:
  - During a RAW hazard, the S2 ALU result is bypassed combinationally into the incoming operand.
  - instr_ready stays 1 and there are no bubbles.
- ALU_FWD_EN undefined:
  - During a RAW hazard, instr_ready = 0 for exactly one cycle.
  - The instruction is accepted at the following edge and reads the written-back value.
  - Exactly one bubble: out_valid is low for one cycle.

## Structure
- Package alu_rf_pkg holds:
  - opcode localparams OP_ADD … OP_MOV;
  - the opcode field width (3);
  - the flag-bundle typedef.
- Sub-module alu_core: purely combinational, parametrised by WIDTH; inputs opcode, a, b; outputs result, overflow, c_out. It is instantiated once in S2.
- The register file, pipeline registers and hazard logic live in the top module.

## Test plan
- Preload R1=0x7FFF, R2=0x0001; ADD R3,R1,R2 -> out=0x8000, overflow=1, c_out=0, out_valid 2 edges after issue; R3 reads back 0x8000.
- SUB R4,R2,R2 -> out=0x0000, c_out=1, overflow=0. Preload R5=0xFFFF; ADD R6,R5,R2 -> out=0x0000, c_out=1, overflow=0.
- Back-to-back ADD R7,R1,R2 then ADD R8,R7,R2 -> second out=0x8001.
  - With ALU_FWD_EN: retires on consecutive cycles, instr_ready never low.
  - Without it: instr_ready low one cycle and one out_valid gap.
- SHL R9,R1 -> 0xFFFE, c_out=0. SHR R10,R2 -> 0x0000, c_out=1. MOV R11,R1 -> 0x7FFF, flags 0.
- Host write R12=0x1234 in the same cycle the pipeline writes R12=0x00AA -> R12=0x00AA. Host write R13=0x5555 alone -> R13=0x5555.
- Assert reset with two instructions in flight -> outputs 0 immediately, no out_valid pulse, all registers read 0 afterwards.
